ahb_sram_ctrl: RTL and testbench
================================

AHB_SRAM_CTRL -- requirements
Module: ahb_sram_ctrl

Interface
REQ-001 SHALL have parameter N_SRAM, default 1: number of SRAM banks.
REQ-002 SHALL have parameter SRAM_WORDS, default 1024: 32-bit words per bank (power of 2).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0: AHB byte address of bank 0, word 0.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: CLK in 1, rising-edge clock; nRST in 1, asynchronous active-low reset.
REQ-005 SHALL have AHB-Lite slave inputs: HSEL 1, HADDR 32, HWRITE 1, HTRANS 2, HSIZE 3, HWDATA 32, HREADY 1.
REQ-006 SHALL have AHB-Lite slave outputs: HRDATA 32, HREADYOUT 1, HRESP 1 (0 OKAY, 1 ERROR).
REQ-007 SHALL have SRAM-side outputs: wen 1, ram_wData 32, addr 32 (byte offset within bank), byte_en 4, sram_en N_SRAM (one-hot bank select).
REQ-008 SHALL have SRAM-side inputs: ram_rData [N_SRAM][32] (per-bank read data), sram_wait 1 (SRAM stall).

Function
REQ-009 SHALL accept a transfer when HSEL & HTRANS[1] & HREADY are all high at a rising edge; IDLE/BUSY transfers get a zero-wait OKAY.
REQ-010 SHALL compute offset = HADDR - BASE_ADDR, bank = offset / (SRAM_WORDS*4), and addr = offset mod (SRAM_WORDS*4).
REQ-011 SHALL decode byte_en as follows: HSIZE 0 gives 4'b0001 << HADDR[1:0]; HSIZE 1 gives 4'b0011 << {HADDR[1],1'b0}; HSIZE 2 gives 4'b1111.
REQ-012 SHALL treat a transfer as an error if any of these hold: bank >= N_SRAM, HADDR < BASE_ADDR, HSIZE > 2, or HADDR misaligned to HSIZE.
REQ-013 SHALL register wen, addr, byte_en and bank at acceptance, so the SRAM is driven in the AHB data phase.
REQ-014 SHALL implement an FSM with states IDLE, ACCESS, ERR1 and ERR2.
REQ-015 SHALL, in IDLE, drive sram_en=0, wen=0, HREADYOUT=1, HRESP=0 and HRDATA=0.
REQ-016 SHALL, in IDLE or ACCESS, go to ACCESS on acceptance of a valid transfer, go to ERR1 on acceptance of an error transfer, and otherwise go to IDLE.
REQ-017 SHALL, in ACCESS, drive: sram_en one-hot on the latched bank, wen latched, addr/byte_en latched, ram_wData = HWDATA (combinational), HREADYOUT = ~sram_wait, HRESP=0.
REQ-018 SHALL, in ACCESS while sram_wait=1, hold state and all SRAM outputs; the HREADY-gated acceptance in REQ-009 blocks any new acceptance.
REQ-019 SHALL, on an ACCESS read, drive HRDATA = ram_rData[bank_q] when sram_wait=0 and 0 otherwise; for an ACCESS write HRDATA=0.
REQ-020 SHALL add zero wait states when sram_wait=0, so back-to-back transfers complete one per cycle.
REQ-021 SHALL, in ERR1, drive HREADYOUT=0, HRESP=1, sram_en=0, and go unconditionally to ERR2.
REQ-022 SHALL, in ERR2, drive HREADYOUT=1, HRESP=1, sram_en=0, and follow the REQ-016 transitions for a transfer sampled in this cycle.
REQ-023 SHALL never issue an SRAM access for an error transfer; no sram_en bit is ever asserted for it.
REQ-024 SHALL, for a read in the address phase that follows a write in its data phase to the same word, return the written data; this holds because the SRAM commits the write before the read is presented.
REQ-025 SHALL ignore sram_wait outside ACCESS.

Reset
REQ-026 SHALL, on nRST low, immediately place the FSM in IDLE and clear all latched registers, regardless of any transfer in progress.
REQ-027 SHALL reset outputs to: HREADYOUT=1, HRESP=0, HRDATA=0, wen=0, sram_en=0, addr=0, byte_en=0, ram_wData=0.
REQ-028 SHALL leave any SRAM access aborted by reset with sram_en deasserted in the same cycle; no write completes after reset asserts.

Structure
REQ-029 SHALL place the following in shared package ahb_sram_pkg: FSM state enum, HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HSIZE encodings, HRESP encodings.
REQ-030 SHALL place the HSIZE/HADDR-to-byte_en and alignment decode in sub-module ahb_sram_be_decode (purely combinational).

Verification
REQ-031 SHALL verify a word write then a read, with N_SRAM=2, SRAM_WORDS=1024, BASE_ADDR=0: NONSEQ write 0x0000_0010 with data 0xDEADBEEF, then NONSEQ read 0x10 -> sram_en=2'b01, wen=1, byte_en=4'hF, addr=0x10; read returns HRDATA=0xDEADBEEF with 0 waits.
REQ-032 SHALL verify bank select and byte access: byte write to HADDR 0x1003 -> sram_en=2'b10, addr=0x3, byte_en=4'b1000.
REQ-033 SHALL verify an SRAM stall: read with sram_wait held high for 3 cycles -> HREADYOUT=0 for 3 cycles, outputs stable, then data returned with HREADYOUT=1.
REQ-034 SHALL verify error responses: access to 0x2000 (out of range) and a halfword at 0x1 (misaligned) -> each gives a two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1) with sram_en never asserted.
REQ-035 SHALL verify reset mid-operation: nRST asserted during a stalled write -> same-cycle sram_en=0, wen=0, HREADYOUT=1, FSM IDLE; the next transfer after reset completes normally.

Source files
------------

// File: rtl/ahb_sram_pkg.sv
// ---------------------------------------------------------------------------
// ahb_sram_pkg
// Shared definitions for the AHB-Lite to SRAM controller:
//   - state_t       : controller FSM states
//   - HTRANS_*      : AHB transfer type encodings
//   - HSIZE_*       : AHB transfer size encodings
//   - HRESP_*       : AHB response encodings
// ---------------------------------------------------------------------------
package ahb_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERR1   = 2'd2,
        ST_ERR2   = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_ctrl_if
// AHB-Lite slave bus bundle for the SRAM controller.
//   master modport : drives address/control/write data and HREADY
//   slave modport  : drives HRDATA, HREADYOUT, HRESP
// ---------------------------------------------------------------------------
interface ahb_sram_ctrl_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

endinterface

// File: rtl/ahb_sram_be_decode.sv
// ---------------------------------------------------------------------------
// ahb_sram_be_decode
// Purely combinational byte-lane decode for an AHB transfer.
//   i_hsize      : HSIZE of the transfer
//   i_addrLow    : HADDR[1:0]
//   o_byteEn     : byte lanes touched by the transfer
//   o_misaligned : address not aligned to the transfer size
//   o_sizeErr    : size wider than a 32-bit word
// ---------------------------------------------------------------------------
module ahb_sram_be_decode
    import ahb_sram_pkg::*;
(
    input  logic [2:0] i_hsize,
    input  logic [1:0] i_addrLow,
    output logic [3:0] o_byteEn,
    output logic       o_misaligned,
    output logic       o_sizeErr
);

    // Sizes above a word produce no lanes and are flagged so the
    // controller can answer with an ERROR response instead.
    always_comb begin
        o_byteEn     = 4'b0000;
        o_misaligned = 1'b0;
        o_sizeErr    = 1'b0;
        case (i_hsize)
            HSIZE_BYTE: begin
                o_byteEn = 4'b0001 << i_addrLow;
            end
            HSIZE_HALF: begin
                o_byteEn     = 4'b0011 << {i_addrLow[1], 1'b0};
                o_misaligned = i_addrLow[0];
            end
            HSIZE_WORD: begin
                o_byteEn     = 4'b1111;
                o_misaligned = |i_addrLow;
            end
            default: begin
                o_sizeErr = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_sram_ctrl
// AHB-Lite slave front end for N_SRAM banks of 32-bit synchronous SRAM.
//   CLK, nRST  : clock, asynchronous active-low reset
//   bus        : AHB-Lite slave bundle (ahb_sram_ctrl_if.slave)
//   wen        : SRAM write enable
//   ram_wData  : SRAM write data (HWDATA passed through in the data phase)
//   addr       : byte offset within the selected bank
//   byte_en    : SRAM byte lane enables
//   sram_en    : one-hot bank select
//   ram_rData  : per-bank read data
//   sram_wait  : SRAM stall, stretches the data phase
// ---------------------------------------------------------------------------
module ahb_sram_ctrl
    import ahb_sram_pkg::*;
#(
    parameter int          N_SRAM     = 1,
    parameter int          SRAM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0
)(
    input  logic                CLK,
    input  logic                nRST,
    ahb_sram_ctrl_if.slave      bus,
    output logic                wen,
    output logic [31:0]         ram_wData,
    output logic [31:0]         addr,
    output logic [3:0]          byte_en,
    output logic [N_SRAM-1:0]   sram_en,
    input  logic [31:0]         ram_rData [N_SRAM],
    input  logic                sram_wait
);

    localparam int          BANK_W      = (N_SRAM > 1) ? $clog2(N_SRAM) : 1;
    localparam int          BANK_SHIFT  = $clog2(SRAM_WORDS * 4);
    localparam logic [31:0] OFFSET_MASK = 32'((SRAM_WORDS * 4) - 1);

    state_t              r_state;
    logic                r_wen;
    logic [31:0]         r_addr;
    logic [3:0]          r_byteEn;
    logic [BANK_W-1:0]   r_bank;

    logic [31:0]         w_offset;
    logic [31:0]         w_bankFull;
    logic [3:0]          w_byteEn;
    logic                w_misaligned;
    logic                w_sizeErr;
    logic                w_active;
    logic                w_accept;
    logic                w_err;

    ahb_sram_be_decode u_beDecode (
        .i_hsize      (bus.HSIZE),
        .i_addrLow    (bus.HADDR[1:0]),
        .o_byteEn     (w_byteEn),
        .o_misaligned (w_misaligned),
        .o_sizeErr    (w_sizeErr)
    );

    // Address-phase decode. The full bank number is kept so that an
    // offset past the last bank is caught even when it would alias
    // onto a valid bank after truncation.
    always_comb begin
        w_offset   = bus.HADDR - BASE_ADDR;
        w_bankFull = w_offset >> BANK_SHIFT;
        w_active   = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);
        w_accept   = bus.HSEL && w_active && bus.HREADY;
        w_err      = (w_bankFull >= 32'(N_SRAM)) || (bus.HADDR < BASE_ADDR) ||
                     w_sizeErr || w_misaligned;
    end

    // Controller FSM. ERR1 always moves to ERR2 (HREADY is low there, so
    // nothing can be accepted). A stalled ACCESS holds state and the
    // latched SRAM controls. Every other state samples a new transfer;
    // error transfers never load the SRAM controls.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= ST_IDLE;
            r_wen    <= 1'b0;
            r_addr   <= '0;
            r_byteEn <= '0;
            r_bank   <= '0;
        end else if (r_state == ST_ERR1) begin
            r_state <= ST_ERR2;
        end else if ((r_state == ST_ACCESS) && sram_wait) begin
            r_state <= ST_ACCESS;
        end else if (w_accept && w_err) begin
            r_state <= ST_ERR1;
        end else if (w_accept) begin
            r_state  <= ST_ACCESS;
            r_wen    <= bus.HWRITE;
            r_addr   <= w_offset & OFFSET_MASK;
            r_byteEn <= w_byteEn;
            r_bank   <= w_bankFull[BANK_W-1:0];
        end else begin
            r_state <= ST_IDLE;
        end
    end

    // Data-phase outputs. Only ACCESS ever enables a bank, so reset (which
    // forces IDLE asynchronously) drops sram_en in the same cycle. Read
    // data is gated to zero while the SRAM is still stalling.
    always_comb begin
        sram_en       = '0;
        wen           = 1'b0;
        addr          = r_addr;
        byte_en       = r_byteEn;
        ram_wData     = 32'h0;
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = HRESP_OKAY;
        bus.HRDATA    = 32'h0;
        case (r_state)
            ST_ACCESS: begin
                for (int i = 0; i < N_SRAM; i++) begin
                    sram_en[i] = (r_bank == BANK_W'(i));
                end
                wen           = r_wen;
                ram_wData     = bus.HWDATA;
                bus.HREADYOUT = ~sram_wait;
                if (!r_wen && !sram_wait) begin
                    bus.HRDATA = ram_rData[r_bank];
                end
            end
            ST_ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = HRESP_ERROR;
            end
            ST_ERR2: begin
                bus.HRESP = HRESP_ERROR;
            end
            default: begin
                bus.HREADYOUT = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_ctrl
// Directed bench for ahb_sram_ctrl with two 1024-word banks at address 0.
// A small byte-lane SRAM model sits behind the controller; HREADY is fed
// back from HREADYOUT as in a single-slave AHB-Lite system.
// ---------------------------------------------------------------------------
module tb_ahb_sram_ctrl
    import ahb_sram_pkg::*;
;

    typedef struct packed {
        logic        write;
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic [31:0] hwdata;
        logic        isErr;
        logic [1:0]  expSramEn;
        logic [3:0]  expBe;
        logic [31:0] expAddr;
        logic [31:0] expRdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        nRst;
    logic        wen;
    logic [31:0] ramWData;
    logic [31:0] addr;
    logic [3:0]  byteEn;
    logic [1:0]  sramEn;
    logic [31:0] ramRData [2];
    logic        sramWait;

    logic [31:0] mem [2][1024];

    int checks = 0;
    int errors = 0;

    vec_t vecs [0:14];

    ahb_sram_ctrl_if bus ();

    assign bus.HREADY = bus.HREADYOUT;

    ahb_sram_ctrl #(
        .N_SRAM     (2),
        .SRAM_WORDS (1024),
        .BASE_ADDR  (32'h0)
    ) dut (
        .CLK       (clk),
        .nRST      (nRst),
        .bus       (bus),
        .wen       (wen),
        .ram_wData (ramWData),
        .addr      (addr),
        .byte_en   (byteEn),
        .sram_en   (sramEn),
        .ram_rData (ramRData),
        .sram_wait (sramWait)
    );

    always #5 clk = ~clk;

    // SRAM model: writes commit on the clock edge that ends an unstalled
    // data phase, reads are combinational from the presented address.
    always @(posedge clk) begin
        if (!sramWait && wen) begin
            for (int b = 0; b < 2; b++) begin
                if (sramEn[b]) begin
                    for (int k = 0; k < 4; k++) begin
                        if (byteEn[k]) begin
                            mem[b][addr[11:2]][8*k +: 8] <= ramWData[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    assign ramRData[0] = mem[0][addr[11:2]];
    assign ramRData[1] = mem[1][addr[11:2]];

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t makeVec(input logic w, input logic [31:0] a, input logic [2:0] s,
                                     input logic [31:0] d, input logic e, input logic [1:0] en,
                                     input logic [3:0] be, input logic [31:0] ad, input logic [31:0] rd);
        vec_t v;
        v.write     = w;
        v.haddr     = a;
        v.hsize     = s;
        v.hwdata    = d;
        v.isErr     = e;
        v.expSramEn = en;
        v.expBe     = be;
        v.expAddr   = ad;
        v.expRdata  = rd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic idleBus();
        bus.HSEL   = 1'b0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HWRITE = 1'b0;
        bus.HADDR  = 32'h0;
        bus.HSIZE  = HSIZE_WORD;
    endtask

    task automatic addressPhase(input logic w, input logic [31:0] a, input logic [2:0] s);
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_NONSEQ;
        bus.HWRITE = w;
        bus.HADDR  = a;
        bus.HSIZE  = s;
    endtask

    // One isolated transfer: address phase, data phase checked at the
    // falling edge, and for errors the second ERROR cycle as well.
    task automatic applyStimulus(input string tag, input vec_t v);
        addressPhase(v.write, v.haddr, v.hsize);
        @(posedge clk); #1;
        idleBus();
        bus.HWDATA = v.hwdata;
        @(negedge clk);
        if (v.isErr) begin
            checkOutput({tag, ".err1.sramEn"}, 32'(sramEn), 32'h0);
            checkOutput({tag, ".err1.wen"}, 32'(wen), 32'h0);
            checkOutput({tag, ".err1.hreadyout"}, 32'(bus.HREADYOUT), 32'h0);
            checkOutput({tag, ".err1.hresp"}, 32'(bus.HRESP), 32'h1);
            checkOutput({tag, ".err1.hrdata"}, bus.HRDATA, 32'h0);
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput({tag, ".err2.sramEn"}, 32'(sramEn), 32'h0);
            checkOutput({tag, ".err2.hreadyout"}, 32'(bus.HREADYOUT), 32'h1);
            checkOutput({tag, ".err2.hresp"}, 32'(bus.HRESP), 32'h1);
        end else begin
            checkOutput({tag, ".sramEn"}, 32'(sramEn), 32'(v.expSramEn));
            checkOutput({tag, ".wen"}, 32'(wen), 32'(v.write));
            checkOutput({tag, ".byteEn"}, 32'(byteEn), 32'(v.expBe));
            checkOutput({tag, ".addr"}, addr, v.expAddr);
            checkOutput({tag, ".hreadyout"}, 32'(bus.HREADYOUT), 32'h1);
            checkOutput({tag, ".hresp"}, 32'(bus.HRESP), 32'h0);
            checkOutput({tag, ".hrdata"}, bus.HRDATA, v.expRdata);
            if (v.write) begin
                checkOutput({tag, ".wdata"}, ramWData, v.hwdata);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        // Transfer vectors: bank 0 is 0x0000-0x0FFF, bank 1 is 0x1000-0x1FFF.
        vecs[0]  = makeVec(1'b1, 32'h0000_0010, HSIZE_WORD, 32'hDEAD_BEEF, 1'b0, 2'b01, 4'hF, 32'h010, 32'h0);
        vecs[1]  = makeVec(1'b0, 32'h0000_0010, HSIZE_WORD, 32'h0,         1'b0, 2'b01, 4'hF, 32'h010, 32'hDEAD_BEEF);
        vecs[2]  = makeVec(1'b1, 32'h0000_1000, HSIZE_WORD, 32'h0,         1'b0, 2'b10, 4'hF, 32'h000, 32'h0);
        vecs[3]  = makeVec(1'b1, 32'h0000_1003, HSIZE_BYTE, 32'hAB00_0000, 1'b0, 2'b10, 4'h8, 32'h003, 32'h0);
        vecs[4]  = makeVec(1'b1, 32'h0000_1004, HSIZE_WORD, 32'h0,         1'b0, 2'b10, 4'hF, 32'h004, 32'h0);
        vecs[5]  = makeVec(1'b1, 32'h0000_1006, HSIZE_HALF, 32'h1234_0000, 1'b0, 2'b10, 4'hC, 32'h006, 32'h0);
        vecs[6]  = makeVec(1'b0, 32'h0000_1000, HSIZE_WORD, 32'h0,         1'b0, 2'b10, 4'hF, 32'h000, 32'hAB00_0000);
        vecs[7]  = makeVec(1'b0, 32'h0000_1004, HSIZE_WORD, 32'h0,         1'b0, 2'b10, 4'hF, 32'h004, 32'h1234_0000);
        vecs[8]  = makeVec(1'b1, 32'h0000_0011, HSIZE_BYTE, 32'h0000_5500, 1'b0, 2'b01, 4'h2, 32'h011, 32'h0);
        vecs[9]  = makeVec(1'b0, 32'h0000_0012, HSIZE_HALF, 32'h0,         1'b0, 2'b01, 4'hC, 32'h012, 32'hDEAD_55EF);
        vecs[10] = makeVec(1'b1, 32'h0000_2000, HSIZE_WORD, 32'h1,         1'b1, 2'b00, 4'h0, 32'h0,   32'h0);
        vecs[11] = makeVec(1'b0, 32'h0000_0001, HSIZE_HALF, 32'h0,         1'b1, 2'b00, 4'h0, 32'h0,   32'h0);
        vecs[12] = makeVec(1'b0, 32'h0000_0000, 3'd3,       32'h0,         1'b1, 2'b00, 4'h0, 32'h0,   32'h0);
        vecs[13] = makeVec(1'b0, 32'h0000_0002, HSIZE_WORD, 32'h0,         1'b1, 2'b00, 4'h0, 32'h0,   32'h0);
        vecs[14] = makeVec(1'b1, 32'h0000_1FFE, HSIZE_HALF, 32'hBEEF_0000, 1'b0, 2'b10, 4'hC, 32'hFFE, 32'h0);

        nRst       = 1'b0;
        sramWait   = 1'b0;
        bus.HWDATA = 32'h0;
        idleBus();

        // Reset values while nRST is held low.
        #1;
        checkOutput("rst.hreadyout", 32'(bus.HREADYOUT), 32'h1);
        checkOutput("rst.hresp", 32'(bus.HRESP), 32'h0);
        checkOutput("rst.hrdata", bus.HRDATA, 32'h0);
        checkOutput("rst.wen", 32'(wen), 32'h0);
        checkOutput("rst.sramEn", 32'(sramEn), 32'h0);
        checkOutput("rst.addr", addr, 32'h0);
        checkOutput("rst.byteEn", 32'(byteEn), 32'h0);
        checkOutput("rst.wdata", ramWData, 32'h0);
        @(posedge clk); #1;
        nRst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // IDLE and BUSY transfers are not accepted: zero-wait OKAY, no SRAM access.
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_BUSY;
        bus.HADDR  = 32'h10;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("busy.sramEn", 32'(sramEn), 32'h0);
        checkOutput("busy.hreadyout", 32'(bus.HREADYOUT), 32'h1);
        checkOutput("busy.hresp", 32'(bus.HRESP), 32'h0);
        idleBus();
        @(posedge clk); #1;

        // sram_wait has no effect outside a data phase.
        sramWait = 1'b1;
        @(negedge clk);
        checkOutput("idleWait.hreadyout", 32'(bus.HREADYOUT), 32'h1);
        checkOutput("idleWait.sramEn", 32'(sramEn), 32'h0);
        sramWait = 1'b0;
        @(posedge clk); #1;

        // Pipelined write then read of the same word, zero wait states.
        addressPhase(1'b1, 32'h20, HSIZE_WORD);
        @(posedge clk); #1;
        addressPhase(1'b0, 32'h20, HSIZE_WORD);
        bus.HWDATA = 32'hCAFE_F00D;
        @(negedge clk);
        checkOutput("b2b.wr.wen", 32'(wen), 32'h1);
        checkOutput("b2b.wr.sramEn", 32'(sramEn), 32'h1);
        checkOutput("b2b.wr.hreadyout", 32'(bus.HREADYOUT), 32'h1);
        checkOutput("b2b.wr.wdata", ramWData, 32'hCAFE_F00D);
        @(posedge clk); #1;
        idleBus();
        @(negedge clk);
        checkOutput("b2b.rd.wen", 32'(wen), 32'h0);
        checkOutput("b2b.rd.addr", addr, 32'h20);
        checkOutput("b2b.rd.hreadyout", 32'(bus.HREADYOUT), 32'h1);
        checkOutput("b2b.rd.hrdata", bus.HRDATA, 32'hCAFE_F00D);
        @(posedge clk); #1;

        // Read stalled for three cycles by the SRAM.
        addressPhase(1'b0, 32'h20, HSIZE_WORD);
        @(posedge clk); #1;
        idleBus();
        sramWait = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("stall%0d.hreadyout", k), 32'(bus.HREADYOUT), 32'h0);
            checkOutput($sformatf("stall%0d.sramEn", k), 32'(sramEn), 32'h1);
            checkOutput($sformatf("stall%0d.addr", k), addr, 32'h20);
            checkOutput($sformatf("stall%0d.hrdata", k), bus.HRDATA, 32'h0);
            @(posedge clk); #1;
        end
        sramWait = 1'b0;
        @(negedge clk);
        checkOutput("stallEnd.hreadyout", 32'(bus.HREADYOUT), 32'h1);
        checkOutput("stallEnd.hrdata", bus.HRDATA, 32'hCAFE_F00D);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("stallIdle.sramEn", 32'(sramEn), 32'h0);
        @(posedge clk); #1;

        // Reset asserted in the middle of a stalled write.
        applyStimulus("rstPre", makeVec(1'b1, 32'h30, HSIZE_WORD, 32'h55AA_55AA, 1'b0, 2'b01, 4'hF, 32'h30, 32'h0));
        addressPhase(1'b1, 32'h30, HSIZE_WORD);
        @(posedge clk); #1;
        idleBus();
        bus.HWDATA = 32'h1111_1111;
        sramWait   = 1'b1;
        @(negedge clk);
        checkOutput("rstMid.stall.wen", 32'(wen), 32'h1);
        checkOutput("rstMid.stall.hreadyout", 32'(bus.HREADYOUT), 32'h0);
        #2;
        nRst     = 1'b0;
        sramWait = 1'b0;
        #1;
        checkOutput("rstMid.sramEn", 32'(sramEn), 32'h0);
        checkOutput("rstMid.wen", 32'(wen), 32'h0);
        checkOutput("rstMid.hreadyout", 32'(bus.HREADYOUT), 32'h1);
        checkOutput("rstMid.hresp", 32'(bus.HRESP), 32'h0);
        checkOutput("rstMid.addr", addr, 32'h0);
        checkOutput("rstMid.byteEn", 32'(byteEn), 32'h0);
        checkOutput("rstMid.wdata", ramWData, 32'h0);
        @(posedge clk); #1;
        nRst = 1'b1;
        @(posedge clk); #1;
        applyStimulus("rstPost", makeVec(1'b0, 32'h30, HSIZE_WORD, 32'h0, 1'b0, 2'b01, 4'hF, 32'h30, 32'h55AA_55AA));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
